// File: rtl/bin2bcd_signed_if.sv
// Handshake and data bundle between the adder-side requester and the
// signed binary-to-BCD converter feeding the 7-segment digit mux.
interface bin2bcd_signed_if #(
  parameter int IN_W = 9
) ();
  logic            start;
  logic [IN_W-1:0] din;
  logic [20:0]     result;
  logic            sign;
  logic            busy;
  logic            done;

  // Requester side: issues operands, watches the converter outputs.
  modport master (
    output start, din,
    input  result, sign, busy, done
  );

  // Converter side.
  modport slave (
    input  start, din,
    output result, sign, busy, done
  );
endinterface

// File: rtl/bin2bcd_signed.sv
// Sequential signed double-dabble converter.
// Converts the magnitude of a two's-complement operand to packed BCD at one
// bit per clock, and reports the operand sign separately (1 = non-negative).
// result/sign only change on the DONE edge or on reset, so the display scan
// never observes a partially converted value.
module bin2bcd_signed #(
  parameter int IN_W   = 9,
  parameter int DIGITS = 4
) (
  input  logic            clk,
  input  logic            rst,
  bin2bcd_signed_if.slave bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CW    = $clog2(IN_W + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]             state;
  logic [IN_W-1:0]        mag;
  logic                   neg;
  logic [BCD_W-1:0]       scratch;
  logic [CW-1:0]          count;
  logic [BCD_W-1:0]       adj;
  logic [BCD_W+IN_W-1:0]  shifted;

  // Add-3 correction on every digit that is 5 or more, then the combined
  // left shift of {scratch, mag} that the SHIFT state commits each edge.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
    shifted = {adj, mag} << 1;
  end

  // Control FSM plus datapath registers; done is a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mag        <= '0;
      neg        <= 1'b0;
      scratch    <= '0;
      count      <= '0;
      bus.result <= '0;
      bus.sign   <= 1'b1;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          bus.busy <= 1'b0;
          if (bus.start) begin
            // Most negative value negates to itself, which read as
            // unsigned is exactly its magnitude.
            mag      <= bus.din[IN_W-1]
                        ? (~bus.din) + {{(IN_W-1){1'b0}}, 1'b1}
                        : bus.din;
            neg      <= bus.din[IN_W-1];
            scratch  <= '0;
            count    <= '0;
            bus.busy <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= shifted[BCD_W+IN_W-1:IN_W];
          mag     <= shifted[IN_W-1:0];
          count   <= count + CW'(1);
          if (count == CW'(IN_W - 1))
            state <= DONE;
        end
        DONE: begin
          bus.result <= {{(21-BCD_W){1'b0}}, scratch};
          bus.sign   <= ~neg;
          bus.done   <= 1'b1;
          bus.busy   <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_signed.sv
// Self-checking bench for bin2bcd_signed: directed cases from the test plan
// plus randomized operands checked against a decimal arithmetic model.
module tb_bin2bcd_signed;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  bin2bcd_signed_if #(.IN_W(9)) bus ();

  bin2bcd_signed #(.IN_W(9), .DIGITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: magnitude split into decimal digits with plain arithmetic.
  function automatic logic [20:0] model_bcd(input logic signed [8:0] v);
    int m;
    logic [20:0] r;
    m = (v < 0) ? -int'(v) : int'(v);
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic logic model_sign(input logic signed [8:0] v);
    return (v >= 0);
  endfunction

  // Issue one operand and wait (bounded) for done; returns in the done cycle.
  task automatic run_conversion(input logic [8:0] v, output int lat,
                                output int busy_cnt, output logic [20:0] r,
                                output logic s);
    @(negedge clk);
    bus.din   = v;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) busy_cnt++;
      lat++;
      @(negedge clk);
    end
    r = bus.result;
    s = bus.sign;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.din   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (bus.result !== 21'h0) begin
      n_fail++; $display("[TB] FAIL reset_result got %h want %h", bus.result, 21'h0);
    end
    n_checks++;
    if (bus.sign !== 1'b1) begin
      n_fail++; $display("[TB] FAIL reset_sign got %b want 1", bus.sign);
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_busy got %b want 0", bus.busy);
    end
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_done got %b want 0", bus.done);
    end
  endtask

  task automatic test_directed();
    logic [8:0]  vals [4];
    int          lat, bc;
    logic [20:0] r;
    logic        s;
    vals = '{9'h07B, 9'h1FF, 9'h100, 9'h0FE};
    foreach (vals[i]) begin
      run_conversion(vals[i], lat, bc, r, s);
      n_checks++;
      if (lat !== 10) begin
        n_fail++; $display("[TB] FAIL latency din=%h got %0d want 10", vals[i], lat);
      end
      n_checks++;
      if (bc !== 10) begin
        n_fail++; $display("[TB] FAIL busy_cycles din=%h got %0d want 10", vals[i], bc);
      end
      n_checks++;
      if (r !== model_bcd(vals[i])) begin
        n_fail++; $display("[TB] FAIL result din=%h got %h want %h", vals[i], r, model_bcd(vals[i]));
      end
      n_checks++;
      if (s !== model_sign(vals[i])) begin
        n_fail++; $display("[TB] FAIL sign din=%h got %b want %b", vals[i], s, model_sign(vals[i]));
      end
      @(negedge clk);
      n_checks++;
      if (bus.done !== 1'b0) begin
        n_fail++; $display("[TB] FAIL done_width din=%h got %b want 0", vals[i], bus.done);
      end
    end
  endtask

  task automatic test_zero_hold();
    int          lat, bc;
    logic [20:0] r;
    logic        s;
    run_conversion(9'h000, lat, bc, r, s);
    n_checks++;
    if (r !== 21'h0) begin
      n_fail++; $display("[TB] FAIL zero_result got %h want 0", r);
    end
    n_checks++;
    if (s !== 1'b1) begin
      n_fail++; $display("[TB] FAIL zero_sign got %b want 1", s);
    end
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      bus.din = 9'($urandom);
      n_checks++;
      if (bus.result !== 21'h0 || bus.sign !== 1'b1 || bus.done !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL idle_hold cycle %0d got %h/%b/%b want 0/1/0",
                 c, bus.result, bus.sign, bus.done);
      end
    end
  endtask

  task automatic test_ignored_start();
    logic [8:0]  v1;
    int          dones;
    logic [20:0] r;
    logic        s;
    v1 = 9'($urandom);
    dones = 0;
    r = '0;
    s = 1'b0;
    @(negedge clk);
    bus.din   = v1;
    bus.start = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 30; c++) begin
      if (c == 3 || c == 7) begin
        bus.start = 1'b1;
        bus.din   = ~v1;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        dones++;
        r = bus.result;
        s = bus.sign;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    n_checks++;
    if (dones !== 1) begin
      n_fail++; $display("[TB] FAIL ignored_start_dones got %0d want 1", dones);
    end
    n_checks++;
    if (r !== model_bcd(v1) || s !== model_sign(v1)) begin
      n_fail++;
      $display("[TB] FAIL ignored_start_value din=%h got %h/%b want %h/%b",
               v1, r, s, model_bcd(v1), model_sign(v1));
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0]  v1, v2;
    int          lat, bc, gap;
    logic [20:0] r;
    logic        s;
    v1 = 9'($urandom);
    v2 = 9'($urandom);
    run_conversion(v1, lat, bc, r, s);
    n_checks++;
    if (r !== model_bcd(v1) || s !== model_sign(v1)) begin
      n_fail++;
      $display("[TB] FAIL b2b_first din=%h got %h/%b want %h/%b",
               v1, r, s, model_bcd(v1), model_sign(v1));
    end
    bus.din   = v2;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    gap = 1;
    while (!bus.done && gap < 40) begin
      gap++;
      @(negedge clk);
    end
    n_checks++;
    if (gap !== 11) begin
      n_fail++; $display("[TB] FAIL b2b_gap got %0d want 11", gap);
    end
    n_checks++;
    if (bus.result !== model_bcd(v2) || bus.sign !== model_sign(v2)) begin
      n_fail++;
      $display("[TB] FAIL b2b_second din=%h got %h/%b want %h/%b",
               v2, bus.result, bus.sign, model_bcd(v2), model_sign(v2));
    end
  endtask

  task automatic test_reset_abort();
    int          lat, bc, dones;
    logic [20:0] r;
    logic        s;
    run_conversion(9'h1D3, lat, bc, r, s);
    n_checks++;
    if (r !== 21'h00045 || s !== 1'b0) begin
      n_fail++; $display("[TB] FAIL neg45 got %h/%b want 00045/0", r, s);
    end
    @(negedge clk);
    bus.din   = 9'd99;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (bus.result !== 21'h0 || bus.sign !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL abort_outputs got %h/%b/%b/%b want 0/1/0/0",
               bus.result, bus.sign, bus.busy, bus.done);
    end
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.done) dones++;
      @(negedge clk);
    end
    n_checks++;
    if (dones !== 0) begin
      n_fail++; $display("[TB] FAIL abort_no_done got %0d want 0", dones);
    end
    run_conversion(9'd99, lat, bc, r, s);
    n_checks++;
    if (r !== 21'h00099 || s !== 1'b1 || lat !== 10) begin
      n_fail++; $display("[TB] FAIL after_abort got %h/%b lat %0d want 00099/1 lat 10", r, s, lat);
    end
  endtask

  task automatic test_random();
    logic [8:0]  v;
    int          lat, bc;
    logic [20:0] r;
    logic        s;
    for (int n = 0; n < 25; n++) begin
      v = 9'($urandom);
      run_conversion(v, lat, bc, r, s);
      n_checks++;
      if (r !== model_bcd(v) || s !== model_sign(v) || lat !== 10) begin
        n_fail++;
        $display("[TB] FAIL random din=%h got %h/%b lat %0d want %h/%b lat 10",
                 v, r, s, lat, model_bcd(v), model_sign(v));
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_directed();
    test_zero_hold();
    test_ignored_start();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
